alu_sequencer: RTL

//  Parametrised successor to the fixed 6-bit ALU controller. Executes a loadable program

---
 rtl/alu_seq_pkg.sv | 56 +++++
 rtl/alu_sequencer_if.sv | 46 ++++
 rtl/alu_seq_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Shared types, default sizes and instruction field offsets for the
//           ALU sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_OPW    = 1;
    localparam int DEF_NREGS  = 4;
    localparam int DEF_PDEPTH = 16;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LDI  = 2'b01,
        CLS_BZ   = 2'b10,
        CLS_HALT = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Instruction word layout, MSB first: {cls, opc, rd, rs1, rs2, imm}
    function automatic int rs2_lsb(input int width);
        return width;
    endfunction

    function automatic int rs1_lsb(input int width, input int rw);
        return width + rw;
    endfunction

    function automatic int rd_lsb(input int width, input int rw);
        return width + 2 * rw;
    endfunction

    function automatic int opc_lsb(input int width, input int rw);
        return width + 3 * rw;
    endfunction

    function automatic int cls_lsb(input int width, input int opw, input int rw);
        return width + 3 * rw + opw;
    endfunction

    function automatic int instr_width(input int width, input int opw, input int rw);
        return 2 + opw + 3 * rw + width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer_if
// Brief   : Host/ALU-facing signal bundle of the ALU sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OPW    = DEF_OPW,
    parameter int NREGS  = DEF_NREGS,
    parameter int PDEPTH = DEF_PDEPTH
);
    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(PDEPTH);
    localparam int IW = instr_width(WIDTH, OPW, RW);

    logic              prog_we;
    logic [PW-1:0]     prog_addr;
    logic [IW-1:0]     prog_data;
    logic              start;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [OPW-1:0]    OP;
    logic [WIDTH-1:0]  result;
    logic              ZF;
    logic              busy;
    logic              done;
    logic [PW-1:0]     pc;
    logic              zf_q;
    logic [RW-1:0]     dbg_sel;
    logic [WIDTH-1:0]  dbg_data;

    modport slave (
        input  prog_we, prog_addr, prog_data, start, result, ZF, dbg_sel,
        output A, B, OP, busy, done, pc, zf_q, dbg_data
    );

    modport master (
        output prog_we, prog_addr, prog_data, start, result, ZF, dbg_sel,
        input  A, B, OP, busy, done, pc, zf_q, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_regfile
// Brief   : NREGS x WIDTH register file, one write port, three async reads.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq_regfile #(
    parameter int WIDTH = 6,
    parameter int NREGS = 4,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [RW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RW-1:0]    i_raddr0,
    input  logic [RW-1:0]    i_raddr1,
    input  logic [RW-1:0]    i_raddr2,
    output logic [WIDTH-1:0] o_rdata0,
    output logic [WIDTH-1:0] o_rdata1,
    output logic [WIDTH-1:0] o_rdata2
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : Program-driven controller that feeds an external ALU and stores
//           its results; fetch/decode/execute, three cycles per instruction.
// Revision: 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int OPW    = DEF_OPW,
    parameter int NREGS  = DEF_NREGS,
    parameter int PDEPTH = DEF_PDEPTH
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam int RW      = $clog2(NREGS);
    localparam int PW      = $clog2(PDEPTH);
    localparam int IW      = instr_width(WIDTH, OPW, RW);
    localparam int RS2_LSB = rs2_lsb(WIDTH);
    localparam int RS1_LSB = rs1_lsb(WIDTH, RW);
    localparam int RD_LSB  = rd_lsb(WIDTH, RW);
    localparam int OPC_LSB = opc_lsb(WIDTH, RW);
    localparam int CLS_LSB = cls_lsb(WIDTH, OPW, RW);
    localparam logic [PW-1:0] PC_ONE = PW'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IW-1:0]    r_ir;
    logic [IW-1:0]    r_pmem [PDEPTH];
    logic [PW-1:0]    r_pc;
    logic [PW-1:0]    w_pc_nxt;
    logic             r_zf;
    logic             w_zf_nxt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;

    cls_e             w_cls;
    logic [OPW-1:0]   w_opc;
    logic [RW-1:0]    w_rd;
    logic [RW-1:0]    w_rs1;
    logic [RW-1:0]    w_rs2;
    logic [WIDTH-1:0] w_imm;
    logic             w_rf_we;
    logic [WIDTH-1:0] w_rf_wdata;
    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;

    assign w_cls = cls_e'(r_ir[CLS_LSB +: 2]);
    assign w_opc = r_ir[OPC_LSB +: OPW];
    assign w_rd  = r_ir[RD_LSB  +: RW];
    assign w_rs1 = r_ir[RS1_LSB +: RW];
    assign w_rs2 = r_ir[RS2_LSB +: RW];
    assign w_imm = r_ir[WIDTH-1:0];

    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RW    (RW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_rf_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_rf_wdata),
        .i_raddr0 (w_rs1),
        .i_raddr1 (w_rs2),
        .i_raddr2 (bus.dbg_sel),
        .o_rdata0 (w_rs1_data),
        .o_rdata1 (w_rs2_data),
        .o_rdata2 (bus.dbg_data)
    );

    // Program memory keeps its contents across reset; writes only while idle.
    always_ff @(posedge clk) begin
        if (bus.prog_we && !r_busy) begin
            r_pmem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_zf_nxt    = r_zf;
        w_rf_we     = 1'b0;
        w_rf_wdata  = bus.result;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = FETCH;
                    w_pc_nxt    = '0;
                end
            end
            FETCH:  w_state_nxt = DECODE;
            DECODE: w_state_nxt = EXEC;
            EXEC: begin
                w_state_nxt = FETCH;
                case (w_cls)
                    CLS_ALU: begin
                        w_rf_we  = 1'b1;
                        w_zf_nxt = bus.ZF;
                        w_pc_nxt = r_pc + PC_ONE;
                    end
                    CLS_LDI: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_imm;
                        w_zf_nxt   = (w_imm == '0);
                        w_pc_nxt   = r_pc + PC_ONE;
                    end
                    CLS_BZ: begin
                        w_pc_nxt = r_zf ? w_imm[PW-1:0] : r_pc + PC_ONE;
                    end
                    default: begin
                        w_state_nxt = DONE;
                    end
                endcase
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ir    <= '0;
            r_pc    <= '0;
            r_zf    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_zf    <= w_zf_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
            if (r_state == FETCH) begin
                r_ir <= r_pmem[r_pc];
            end
            // Operands latch here, so rd==rs aliasing sees pre-write values.
            if (r_state == DECODE) begin
                r_a  <= w_rs1_data;
                r_b  <= w_rs2_data;
                r_op <= w_opc;
            end
        end
    end

    assign bus.A    = r_a;
    assign bus.B    = r_b;
    assign bus.OP   = r_op;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.pc   = r_pc;
    assign bus.zf_q = r_zf;

endmodule
`default_nettype wire
